// File: rtl/ristretto_lsu_lane.sv
// ristretto_lsu_lane: load/store unit for the execute stage.
// Aligns byte lanes from the low EA bits, sign/zero-extends loads, replicates
// store data, traps misaligned accesses locally and turns bus errors or
// handshake timeouts into access faults with a single-cycle done pulse.
module ristretto_lsu_lane #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      lsu_op_en_i,
  input  logic                      lsu_op_i,
  input  logic [1:0]                lsu_op_size_i,
  input  logic                      lsu_unsigned_i,
  input  logic [AddressWidth-1:0]   lsu_op_addr_i,
  input  logic [11:0]               lsu_woffset_i,
  input  logic [DataWidth-1:0]      lsu_op_data_i,
  input  logic                      lsu_rdata_ready_i,
  input  logic                      lsu_rdata_valid_i,
  input  logic                      lsu_rdata_err_i,
  input  logic [DataWidth-1:0]      lsu_rdata_data_i,
  output logic                      lsu_rdata_req_o,
  output logic [AddressWidth-1:0]   lsu_rdata_addr_o,
  output logic [DataWidth/8-1:0]    lsu_rdata_strb_o,
  input  logic                      lsu_wdata_ready_i,
  input  logic                      lsu_wdata_valid_i,
  input  logic                      lsu_wdata_err_i,
  output logic                      lsu_wdata_req_o,
  output logic [AddressWidth-1:0]   lsu_wdata_addr_o,
  output logic [DataWidth/8-1:0]    lsu_wdata_strb_o,
  output logic [DataWidth-1:0]      lsu_wdata_data_o,
  output logic                      lsu_busy_o,
  output logic                      lsu_done_o,
  output logic [DataWidth-1:0]      lsu_result_o,
  output logic [1:0]                lsu_misalig_op_o,
  output logic [1:0]                lsu_fault_op_o,
  output logic [AddressWidth-1:0]   lsu_invalid_addr_o
);

  localparam int NB = DataWidth / 8;
  localparam int OB = $clog2(NB);
  // Counter only ever needs to reach TimeoutCycles-1.
  localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic                    r_op, r_uns;
  logic [1:0]              r_size;
  logic [OB-1:0]           r_off;
  logic [AddressWidth-1:0] r_ea, r_maddr;
  logic [NB-1:0]           r_strb;
  logic [DataWidth-1:0]    r_wdata;
  logic [CW-1:0]           r_cnt;
  logic                    r_done;
  logic [1:0]              r_misalig, r_fault;
  logic [AddressWidth-1:0] r_inv;
  logic [DataWidth-1:0]    r_result;

  logic [AddressWidth-1:0] w_ea;
  logic [OB-1:0]           w_off;
  logic                    w_misal;
  logic [7:0]              w_len;
  logic [NB-1:0]           w_strb;
  logic [DataWidth-1:0]    w_wdata;
  logic [DataWidth-1:0]    w_sh, w_mask, w_ext;
  logic                    w_sbit;
  logic                    w_ready, w_valid, w_err, w_tmo;
  logic                    w_accept, w_misal_ev, w_resp, w_abort, w_fault_ev;
  logic                    w_req, w_busy;

  // Effective address: stores add the sign-extended 12-bit offset.
  assign w_ea  = lsu_op_i ? lsu_op_addr_i + {{(AddressWidth-12){lsu_woffset_i[11]}}, lsu_woffset_i}
                          : lsu_op_addr_i;
  assign w_off = w_ea[OB-1:0];

  // Alignment check, byte-length mask, and store data replication per size.
  always_comb begin
    w_misal = 1'b0;
    w_len   = 8'h01;
    w_wdata = {NB{lsu_op_data_i[7:0]}};
    case (lsu_op_size_i)
      2'b00: ;
      2'b01: begin
        w_misal = w_ea[0];
        w_len   = 8'h03;
        w_wdata = {(NB/2){lsu_op_data_i[15:0]}};
      end
      2'b10: begin
        w_misal = (w_ea[1:0] != 2'b00);
        w_len   = 8'h0F;
        w_wdata = {(NB/4){lsu_op_data_i[31:0]}};
      end
      default: begin
        // Dword only exists on a 64-bit bus.
        w_misal = (DataWidth == 32) || (w_ea[2:0] != 3'b000);
        w_len   = 8'hFF;
        w_wdata = lsu_op_data_i;
      end
    endcase
  end

  assign w_strb = NB'(w_len) << w_off;

  // Only the port chosen by the in-flight op participates in the handshake.
  assign w_ready = r_op ? lsu_wdata_ready_i : lsu_rdata_ready_i;
  assign w_valid = r_op ? lsu_wdata_valid_i : lsu_rdata_valid_i;
  assign w_err   = r_op ? lsu_wdata_err_i   : lsu_rdata_err_i;
  assign w_tmo   = (TimeoutCycles != 0) && (r_cnt == CW'(TimeoutCycles - 1));

  assign w_accept   = (r_state == S_IDLE) && lsu_op_en_i && !w_misal;
  assign w_misal_ev = (r_state == S_IDLE) && lsu_op_en_i && w_misal;
  // A response is only looked at once the request has been accepted.
  assign w_resp     = (r_state == S_RESP) && w_valid;
  // A response arriving on the timeout cycle still completes normally.
  assign w_abort    = (r_state != S_IDLE) && w_tmo && !w_resp;
  assign w_fault_ev = (w_resp && w_err) || w_abort;

  // Load alignment and extension: shift the addressed lane down, then mask/extend.
  assign w_sh = lsu_rdata_data_i >> {r_off, 3'b000};
  always_comb begin
    w_mask = '1;
    w_sbit = 1'b0;
    case (r_size)
      2'b00:   begin w_mask = DataWidth'(8'hFF);         w_sbit = w_sh[7];  end
      2'b01:   begin w_mask = DataWidth'(16'hFFFF);      w_sbit = w_sh[15]; end
      2'b10:   begin w_mask = DataWidth'(32'hFFFF_FFFF); w_sbit = w_sh[31]; end
      default: begin w_mask = '1;                        w_sbit = 1'b0;     end
    endcase
  end
  assign w_ext = (w_sh & w_mask) | ((!r_uns && w_sbit) ? ~w_mask : '0);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ:   if (w_tmo) w_state_nxt = S_IDLE;
               else if (w_ready) w_state_nxt = S_RESP;
      S_RESP:  if (w_valid || w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request and busy follow the state register directly so reset drops them at once.
  always_comb begin
    w_req  = (r_state == S_REQ);
    w_busy = (r_state != S_IDLE);
  end

  // Capture the accepted request; held unchanged until the op retires.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_op    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_off   <= '0;
      r_ea    <= '0;
      r_maddr <= '0;
      r_strb  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_op    <= lsu_op_i;
      r_uns   <= lsu_unsigned_i;
      r_size  <= lsu_op_size_i;
      r_off   <= w_off;
      r_ea    <= w_ea;
      r_maddr <= {w_ea[AddressWidth-1:OB], {OB{1'b0}}};
      r_strb  <= w_strb;
      r_wdata <= w_wdata;
    end
  end

  // Timeout counter: cleared on entry to REQ, counts every busy cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state != S_IDLE)  r_cnt <= r_cnt + 1'b1;
  end

  // Completion pulse and its qualifying status, zero outside the pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_done    <= 1'b0;
      r_misalig <= 2'b00;
      r_fault   <= 2'b00;
      r_inv     <= '0;
    end else begin
      r_done    <= w_misal_ev || w_resp || w_abort;
      r_misalig <= w_misal_ev ? (lsu_op_i ? 2'b10 : 2'b01) : 2'b00;
      r_fault   <= w_fault_ev ? (r_op ? 2'b10 : 2'b01) : 2'b00;
      r_inv     <= w_misal_ev ? w_ea : (w_fault_ev ? r_ea : '0);
    end
  end

  // Load result: only successful loads overwrite it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                           r_result <= '0;
    else if (w_resp && !w_err && !r_op)    r_result <= w_ext;
  end

  assign lsu_rdata_req_o    = w_req && !r_op;
  assign lsu_rdata_addr_o   = lsu_rdata_req_o ? r_maddr : '0;
  assign lsu_rdata_strb_o   = lsu_rdata_req_o ? r_strb  : '0;
  assign lsu_wdata_req_o    = w_req && r_op;
  assign lsu_wdata_addr_o   = lsu_wdata_req_o ? r_maddr : '0;
  assign lsu_wdata_strb_o   = lsu_wdata_req_o ? r_strb  : '0;
  assign lsu_wdata_data_o   = lsu_wdata_req_o ? r_wdata : '0;
  assign lsu_busy_o         = w_busy;
  assign lsu_done_o         = r_done;
  assign lsu_result_o       = r_result;
  assign lsu_misalig_op_o   = r_misalig;
  assign lsu_fault_op_o     = r_fault;
  assign lsu_invalid_addr_o = r_inv;

endmodule

// File: tb/tb_ristretto_lsu_lane.sv
// Directed bench: a 32-bit lane with an 8-cycle timeout and a 64-bit lane
// without timeout, driven from one linear stimulus sequence.
module tb_ristretto_lsu_lane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // 32-bit instance signals
  logic        a_rstn, a_en, a_op, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_opdata, a_rdata;
  logic [11:0] a_woff;
  logic        a_rrdy, a_rvld, a_rerr, a_wrdy, a_wvld, a_werr;
  logic        a_rreq, a_wreq, a_busy, a_done;
  logic [31:0] a_raddr, a_waddr, a_wdata, a_result, a_inv;
  logic [3:0]  a_rstrb, a_wstrb;
  logic [1:0]  a_misal, a_fault;

  // 64-bit instance signals
  logic        b_rstn, b_en, b_op, b_uns;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_opdata, b_rdata;
  logic [11:0] b_woff;
  logic        b_rrdy, b_rvld, b_rerr, b_wrdy, b_wvld, b_werr;
  logic        b_rreq, b_wreq, b_busy, b_done;
  logic [31:0] b_raddr, b_waddr, b_inv;
  logic [63:0] b_wdata, b_result;
  logic [7:0]  b_rstrb, b_wstrb;
  logic [1:0]  b_misal, b_fault;

  ristretto_lsu_lane #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(8)) u_a (
    .clk_i(clk), .rstn_i(a_rstn), .lsu_op_en_i(a_en), .lsu_op_i(a_op),
    .lsu_op_size_i(a_size), .lsu_unsigned_i(a_uns), .lsu_op_addr_i(a_addr),
    .lsu_woffset_i(a_woff), .lsu_op_data_i(a_opdata),
    .lsu_rdata_ready_i(a_rrdy), .lsu_rdata_valid_i(a_rvld), .lsu_rdata_err_i(a_rerr),
    .lsu_rdata_data_i(a_rdata), .lsu_rdata_req_o(a_rreq), .lsu_rdata_addr_o(a_raddr),
    .lsu_rdata_strb_o(a_rstrb), .lsu_wdata_ready_i(a_wrdy), .lsu_wdata_valid_i(a_wvld),
    .lsu_wdata_err_i(a_werr), .lsu_wdata_req_o(a_wreq), .lsu_wdata_addr_o(a_waddr),
    .lsu_wdata_strb_o(a_wstrb), .lsu_wdata_data_o(a_wdata), .lsu_busy_o(a_busy),
    .lsu_done_o(a_done), .lsu_result_o(a_result), .lsu_misalig_op_o(a_misal),
    .lsu_fault_op_o(a_fault), .lsu_invalid_addr_o(a_inv)
  );

  ristretto_lsu_lane #(.DataWidth(64), .AddressWidth(32), .TimeoutCycles(0)) u_b (
    .clk_i(clk), .rstn_i(b_rstn), .lsu_op_en_i(b_en), .lsu_op_i(b_op),
    .lsu_op_size_i(b_size), .lsu_unsigned_i(b_uns), .lsu_op_addr_i(b_addr),
    .lsu_woffset_i(b_woff), .lsu_op_data_i(b_opdata),
    .lsu_rdata_ready_i(b_rrdy), .lsu_rdata_valid_i(b_rvld), .lsu_rdata_err_i(b_rerr),
    .lsu_rdata_data_i(b_rdata), .lsu_rdata_req_o(b_rreq), .lsu_rdata_addr_o(b_raddr),
    .lsu_rdata_strb_o(b_rstrb), .lsu_wdata_ready_i(b_wrdy), .lsu_wdata_valid_i(b_wvld),
    .lsu_wdata_err_i(b_werr), .lsu_wdata_req_o(b_wreq), .lsu_wdata_addr_o(b_waddr),
    .lsu_wdata_strb_o(b_wstrb), .lsu_wdata_data_o(b_wdata), .lsu_busy_o(b_busy),
    .lsu_done_o(b_done), .lsu_result_o(b_result), .lsu_misalig_op_o(b_misal),
    .lsu_fault_op_o(b_fault), .lsu_invalid_addr_o(b_inv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge(s).
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    a_rstn = 0; a_en = 0; a_op = 0; a_uns = 0; a_size = 0; a_addr = 0; a_woff = 0;
    a_opdata = 0; a_rdata = 0; a_rrdy = 0; a_rvld = 0; a_rerr = 0;
    a_wrdy = 0; a_wvld = 0; a_werr = 0;
    b_rstn = 0; b_en = 0; b_op = 0; b_uns = 0; b_size = 0; b_addr = 0; b_woff = 0;
    b_opdata = 0; b_rdata = 0; b_rrdy = 0; b_rvld = 0; b_rerr = 0;
    b_wrdy = 0; b_wvld = 0; b_werr = 0;
    step(2);

    // Reset state
    chk("rst_rreq",   a_rreq,   0);
    chk("rst_busy",   a_busy,   0);
    chk("rst_done",   a_done,   0);
    chk("rst_result", a_result, 0);
    chk("rst_inv",    a_inv,    0);
    a_rstn = 1; b_rstn = 1;
    step();

    // Load byte signed at 0x1003, rdata 0x80AABBCC -> 0xFFFFFF80
    a_en = 1; a_op = 0; a_size = 2'b00; a_uns = 0; a_addr = 32'h1003;
    step();
    a_en = 0; a_rrdy = 1;
    chk("lb_rreq",  a_rreq,  1);
    chk("lb_busy",  a_busy,  1);
    chk("lb_raddr", a_raddr, 32'h1000);
    chk("lb_rstrb", a_rstrb, 4'b1000);
    chk("lb_wreq",  a_wreq,  0);
    step();
    a_rrdy = 0; a_rvld = 1; a_rdata = 32'h80AABBCC;
    chk("lb_req_drop", a_rreq, 0);
    chk("lb_resp_busy", a_busy, 1);
    step();
    a_rvld = 0;
    chk("lb_done",   a_done,   1);
    chk("lb_busy0",  a_busy,   0);
    chk("lb_result", a_result, 32'hFFFFFF80);
    chk("lb_fault",  a_fault,  0);
    step();
    chk("lb_done_pulse", a_done, 0);

    // Store half, base 0x2000 + sext(0xFFE) -> EA 0x1FFE
    a_en = 1; a_op = 1; a_size = 2'b01; a_addr = 32'h2000; a_woff = 12'hFFE; a_opdata = 32'h0000_1234;
    step();
    a_en = 0; a_wrdy = 1;
    chk("sh_wreq",  a_wreq,  1);
    chk("sh_rreq",  a_rreq,  0);
    chk("sh_waddr", a_waddr, 32'h1FFC);
    chk("sh_wstrb", a_wstrb, 4'b1100);
    chk("sh_wdata", a_wdata, 32'h12341234);
    step();
    a_wrdy = 0; a_wvld = 1;
    step();
    a_wvld = 0;
    chk("sh_done",   a_done,   1);
    chk("sh_fault",  a_fault,  0);
    chk("sh_result", a_result, 32'hFFFFFF80);

    // Misaligned load word at 0x1002
    a_en = 1; a_op = 0; a_size = 2'b10; a_addr = 32'h1002;
    step();
    a_en = 0;
    chk("mis_done",  a_done,  1);
    chk("mis_code",  a_misal, 2'b01);
    chk("mis_inv",   a_inv,   32'h1002);
    chk("mis_busy",  a_busy,  0);
    chk("mis_rreq",  a_rreq,  0);
    step();
    chk("mis_done0", a_done,  0);
    chk("mis_code0", a_misal, 0);
    chk("mis_inv0",  a_inv,   0);

    // Store word with bus error, EA 0x3000 + 4
    a_en = 1; a_op = 1; a_size = 2'b10; a_addr = 32'h3000; a_woff = 12'h004; a_opdata = 32'hDEADBEEF;
    step();
    a_en = 0; a_wrdy = 1;
    chk("sw_wstrb", a_wstrb, 4'b1111);
    chk("sw_wdata", a_wdata, 32'hDEADBEEF);
    step();
    a_wrdy = 0; a_wvld = 1; a_werr = 1;
    step();
    a_wvld = 0; a_werr = 0;
    chk("sw_err_done",   a_done,   1);
    chk("sw_err_fault",  a_fault,  2'b10);
    chk("sw_err_inv",    a_inv,    32'h3004);
    chk("sw_err_result", a_result, 32'hFFFFFF80);

    // Timeout: load word at 0x4000, never ready
    step();
    a_en = 1; a_op = 0; a_size = 2'b10; a_addr = 32'h4000;
    step();
    a_en = 0;
    chk("to_req_first", a_rreq, 1);
    step(7);
    chk("to_req_last",  a_rreq, 1);
    chk("to_done_early", a_done, 0);
    step();
    chk("to_req_drop", a_rreq,  0);
    chk("to_busy",     a_busy,  0);
    chk("to_done",     a_done,  1);
    chk("to_fault",    a_fault, 2'b01);
    chk("to_inv",      a_inv,   32'h4000);
    a_rvld = 1; a_rdata = 32'h12345678;
    step();
    a_rvld = 0;
    chk("to_stray_done",   a_done,   0);
    chk("to_stray_result", a_result, 32'hFFFFFF80);

    // New op after timeout: load half unsigned at 0x1002
    a_en = 1; a_op = 0; a_size = 2'b01; a_uns = 1; a_addr = 32'h1002;
    step();
    a_en = 0; a_rrdy = 1;
    chk("lhu_rstrb", a_rstrb, 4'b1100);
    step();
    a_rrdy = 0; a_rvld = 1; a_rdata = 32'h89AB0000;
    step();
    a_rvld = 0; a_uns = 0;
    chk("lhu_done",   a_done,   1);
    chk("lhu_result", a_result, 32'h000089AB);

    // 64-bit: load dword at 0x08
    b_en = 1; b_op = 0; b_size = 2'b11; b_addr = 32'h08;
    step();
    b_en = 0; b_rrdy = 1;
    chk("ld_rstrb", b_rstrb, 8'hFF);
    chk("ld_raddr", b_raddr, 32'h08);
    step();
    b_rrdy = 0; b_rvld = 1; b_rdata = 64'hBEEF000000000000;
    step();
    b_rvld = 0;
    chk("ld_done",   b_done,   1);
    chk("ld_result", b_result, 64'hBEEF000000000000);

    // 64-bit: load half unsigned at 0x0E
    b_en = 1; b_size = 2'b01; b_uns = 1; b_addr = 32'h0E;
    step();
    b_en = 0; b_rrdy = 1;
    chk("lh64_rstrb", b_rstrb, 8'hC0);
    chk("lh64_raddr", b_raddr, 32'h08);
    step();
    b_rrdy = 0; b_rvld = 1;
    step();
    b_rvld = 0; b_uns = 0;
    chk("lh64_result", b_result, 64'h000000000000BEEF);

    // 64-bit: load word signed at 0x0C
    b_en = 1; b_size = 2'b10; b_addr = 32'h0C;
    step();
    b_en = 0; b_rrdy = 1;
    chk("lw64_rstrb", b_rstrb, 8'hF0);
    step();
    b_rrdy = 0; b_rvld = 1; b_rdata = 64'h8000000100000000;
    step();
    b_rvld = 0;
    chk("lw64_result", b_result, 64'hFFFFFFFF80000001);

    // 64-bit: async reset during RESP
    b_en = 1; b_size = 2'b10; b_addr = 32'h10;
    step();
    b_en = 0; b_rrdy = 1;
    step();
    b_rrdy = 0;
    chk("rr_busy", b_busy, 1);
    #2 b_rstn = 0;
    #1;
    chk("rr_busy0", b_busy, 0);
    chk("rr_rreq0", b_rreq, 0);
    step();
    chk("rr_done0", b_done, 0);
    b_rstn = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
